// File: rtl/add_n_pipe.sv
// Pipelined balanced-tree adder of N DW-bit elements with valid/ready flow control.
// Optional build macro ADD_N_PIPE_SAT_EN saturates the result instead of wrapping it.
module add_n_pipe #(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int SIGNED = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW*N-1:0] inp,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [DW-1:0]   outp,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam int L  = $clog2(N);
  localparam int FW = DW + L;
  localparam int NP = 1 << L;

  // Level k only needs DW+k bits; the extra high bits are extension copies
  // of the same value, so one storage width serves every level.
  logic [FW-1:0] leaf [0:NP-1];
  logic [FW-1:0] node [1:L][0:NP/2-1];
  logic [L:1]    vld;
  logic          adv;
  logic [FW-1:0] sum;

  assign adv       = !vld[L] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld[L];
  assign sum       = node[L][0];

  // Leaves past N stay zero so odd nodes pass straight through their level.
  always_comb begin
    for (int i = 0; i < NP; i++) leaf[i] = '0;
    for (int i = 0; i < N; i++) begin
      if (SIGNED != 0)
        leaf[i] = {{L{inp[i*DW+DW-1]}}, inp[i*DW +: DW]};
      else
        leaf[i] = {{L{1'b0}}, inp[i*DW +: DW]};
    end
  end

  // Data registers load only when a valid item enters them, so outp keeps
  // its last value while bubbles drain through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int k = 1; k <= L; k++)
        for (int j = 0; j < NP/2; j++)
          node[k][j] <= '0;
    end else if (adv) begin
      vld[1] <= in_valid;
      for (int k = 2; k <= L; k++) vld[k] <= vld[k-1];
      if (in_valid)
        for (int j = 0; j < NP/2; j++)
          node[1][j] <= leaf[2*j] + leaf[2*j+1];
      for (int k = 2; k <= L; k++)
        if (vld[k-1])
          for (int j = 0; j < (NP >> k); j++)
            node[k][j] <= node[k-1][2*j] + node[k-1][2*j+1];
    end
  end

`ifdef ADD_N_PIPE_SAT_EN
  always_comb begin
    outp = sum[DW-1:0];
    if (SIGNED != 0) begin
      if (sum[FW-1:DW-1] != {(L+1){sum[FW-1]}})
        outp = sum[FW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      if (sum[FW-1:DW] != '0)
        outp = '1;
    end
  end
`else
  logic sum_hi_unused;
  assign sum_hi_unused = ^sum[FW-1:DW];
  assign outp = sum[DW-1:0];
`endif

endmodule

// File: tb/tb_add_n_pipe.sv
// Directed bench for add_n_pipe: four configurations share one clock and reset.
// Slot 0: N=4 unsigned, 1: N=4 signed, 2: N=5 unsigned, 3: N=3 unsigned.
module tb_add_n_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] inp_a       [4];
  logic        in_valid_a  [4];
  logic        out_ready_a [4];
  logic        in_ready_a  [4];
  logic        out_valid_a [4];
  logic [7:0]  outp_a      [4];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  add_n_pipe #(.N(4), .DW(8), .SIGNED(0)) u4 (
    .clk(clk), .rst(rst), .inp(inp_a[0][31:0]), .in_valid(in_valid_a[0]),
    .in_ready(in_ready_a[0]), .outp(outp_a[0]), .out_valid(out_valid_a[0]),
    .out_ready(out_ready_a[0]));
  add_n_pipe #(.N(4), .DW(8), .SIGNED(1)) u4s (
    .clk(clk), .rst(rst), .inp(inp_a[1][31:0]), .in_valid(in_valid_a[1]),
    .in_ready(in_ready_a[1]), .outp(outp_a[1]), .out_valid(out_valid_a[1]),
    .out_ready(out_ready_a[1]));
  add_n_pipe #(.N(5), .DW(8), .SIGNED(0)) u5 (
    .clk(clk), .rst(rst), .inp(inp_a[2]), .in_valid(in_valid_a[2]),
    .in_ready(in_ready_a[2]), .outp(outp_a[2]), .out_valid(out_valid_a[2]),
    .out_ready(out_ready_a[2]));
  add_n_pipe #(.N(3), .DW(8), .SIGNED(0)) u3 (
    .clk(clk), .rst(rst), .inp(inp_a[3][23:0]), .in_valid(in_valid_a[3]),
    .in_ready(in_ready_a[3]), .outp(outp_a[3]), .out_valid(out_valid_a[3]),
    .out_ready(out_ready_a[3]));

`ifdef ADD_N_PIPE_SAT_EN
  localparam logic [7:0] E_U300  = 8'd255;
  localparam logic [7:0] E_U1020 = 8'd255;
  localparam logic [7:0] E_SM256 = 8'h80;
  localparam logic [7:0] E_S254  = 8'h7F;
  localparam logic [7:0] E_SM150 = 8'h80;
`else
  localparam logic [7:0] E_U300  = 8'd44;
  localparam logic [7:0] E_U1020 = 8'd252;
  localparam logic [7:0] E_SM256 = 8'h00;
  localparam logic [7:0] E_S254  = 8'hFE;
  localparam logic [7:0] E_SM150 = 8'h6A;
`endif

  typedef struct packed {
    logic [1:0] s;
    logic [7:0] e3, e2, e1, e0;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic apply_vec(input int s, input logic [39:0] v, input logic [7:0] exp,
                           input int lat, input string nm);
    int n;
    @(negedge clk);
    inp_a[s]       = v;
    in_valid_a[s]  = 1'b1;
    out_ready_a[s] = 1'b1;
    #1;
    chk({nm, "_in_ready"}, in_ready_a[s], 1);
    @(posedge clk);
    #1;
    in_valid_a[s] = 1'b0;
    n = 1;
    while (!out_valid_a[s] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_latency"}, n, lat);
    chk({nm, "_outp"}, outp_a[s], exp);
  endtask

  function automatic logic [39:0] vec5(input int v);
    logic [39:0] r;
    for (int i = 0; i < 5; i++) r[i*8 +: 8] = 8'(5*v + i + 1);
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int sent, got;
    tbl[0] = '{s:2'd0, e3:8'd4,   e2:8'd3,   e1:8'd2,   e0:8'd1,   exp:8'd10};
    tbl[1] = '{s:2'd0, e3:8'd0,   e2:8'd0,   e1:8'd100, e0:8'd200, exp:E_U300};
    tbl[2] = '{s:2'd0, e3:8'd255, e2:8'd255, e1:8'd255, e0:8'd255, exp:E_U1020};
    tbl[3] = '{s:2'd0, e3:8'd5,   e2:8'd25,  e1:8'd50,  e0:8'd100, exp:8'd180};
    tbl[4] = '{s:2'd0, e3:8'd0,   e2:8'd0,   e1:8'd0,   e0:8'd0,   exp:8'd0};
    tbl[5] = '{s:2'd1, e3:8'h00,  e2:8'h00,  e1:8'h80,  e0:8'h80,  exp:E_SM256};
    tbl[6] = '{s:2'd1, e3:8'h01,  e2:8'hFF,  e1:8'h05,  e0:8'hFD,  exp:8'h02};
    tbl[7] = '{s:2'd1, e3:8'h00,  e2:8'h00,  e1:8'h7F,  e0:8'h7F,  exp:E_S254};
    tbl[8] = '{s:2'd1, e3:8'hFF,  e2:8'hFF,  e1:8'hFF,  e0:8'hFF,  exp:8'hFC};
    tbl[9] = '{s:2'd1, e3:8'h00,  e2:8'h32,  e1:8'h9C,  e0:8'h9C,  exp:E_SM150};

    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inp_a[i] = '0; in_valid_a[i] = 1'b0; out_ready_a[i] = 1'b1;
    end
    #1;
    chk("rst_out_valid", out_valid_a[0], 0);
    chk("rst_outp", outp_a[0], 0);
    chk("rst_in_ready", in_ready_a[0], 1);
    chk("rst_out_valid_n3", out_valid_a[3], 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      apply_vec(int'(tbl[i].s), {8'd0, tbl[i].e3, tbl[i].e2, tbl[i].e1, tbl[i].e0},
                tbl[i].exp, 2, $sformatf("vec%0d", i));

    // N=5: back-to-back vectors with a five-cycle consumer stall.
    sent = 0;
    got  = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      in_valid_a[2]  = (sent < 8);
      inp_a[2]       = vec5(sent);
      out_ready_a[2] = !(c >= 3 && c <= 7);
      #1;
      if (c >= 3 && c <= 7) begin
        chk("n5_full_in_ready", in_ready_a[2], 0);
        chk("n5_hold_valid", out_valid_a[2], 1);
        chk("n5_hold_outp", outp_a[2], 15);
      end
      if (out_valid_a[2] && out_ready_a[2]) begin
        chk($sformatf("n5_sum%0d", got), outp_a[2], 25*got + 15);
        got++;
      end
      if (in_valid_a[2] && in_ready_a[2]) sent++;
    end
    chk("n5_delivered", got, 8);
    @(negedge clk);
    in_valid_a[2] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("n5_no_extra", out_valid_a[2], 0);
    end

    // N=4: asynchronous reset with two vectors in flight.
    @(negedge clk);
    inp_a[0] = {8'd44, 8'd33, 8'd22, 8'd11};
    in_valid_a[0]  = 1'b1;
    out_ready_a[0] = 1'b0;
    @(negedge clk);
    inp_a[0] = {8'd5, 8'd5, 8'd5, 8'd5};
    @(posedge clk);
    #1;
    in_valid_a[0] = 1'b0;
    chk("pre_rst_valid", out_valid_a[0], 1);
    chk("pre_rst_outp", outp_a[0], 110);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid_a[0], 0);
    chk("async_rst_outp", outp_a[0], 0);
    chk("async_rst_in_ready", in_ready_a[0], 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready_a[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_stale", out_valid_a[0], 0);
    end
    apply_vec(0, {8'd0, 8'd1, 8'd1, 8'd1, 8'd1}, 8'd4, 2, "post_rst");

    // N=3: vector every other cycle; outp must hold through the bubbles.
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      in_valid_a[3]  = (c % 2 == 0) && (c <= 8);
      inp_a[3]       = {16'd0, 8'd9, 8'd8, 8'd7};
      out_ready_a[3] = 1'b1;
      #1;
      if (c >= 2) begin
        chk($sformatf("n3_valid_c%0d", c), out_valid_a[3], ((c % 2 == 0) && (c <= 10)) ? 1 : 0);
        chk($sformatf("n3_outp_c%0d", c), outp_a[3], 24);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/add_n_pipe.md
ADD_N_PIPE -- requirements
Module: add_n_pipe

Interface
REQ-001 SHALL have parameter N, default 4: number of DW-bit elements summed; legal range 2..64.
REQ-002 SHALL have parameter DW, default 8: element and result bitwidth; legal range 2..32.
REQ-003 SHALL have parameter SIGNED, default 0: 0 treats elements as unsigned, 1 as two's complement.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port inp, input, DW*N bits: element i occupies bits [(i+1)*DW-1 : i*DW].
REQ-007 SHALL have port in_valid, input, 1 bit: inp holds a vector to sum.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts inp this cycle.
REQ-009 SHALL have port outp, output, DW bits: sum result.
REQ-010 SHALL have port out_valid, output, 1 bit: outp holds a result.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer takes outp this cycle.

Function
REQ-012 SHALL sum the N elements as a balanced binary tree of L = ceil(log2 N) levels, one register stage per level.
REQ-013 SHALL treat missing tree leaves (N not a power of two) as zero, so an odd node passes through its level unchanged.
REQ-014 SHALL carry full precision internally: level k operands DW+k bits, sign-extended when SIGNED=1, zero-extended otherwise.
REQ-015 SHALL accept a vector when in_valid && in_ready.
REQ-016 SHALL present the result exactly L cycles after acceptance if never stalled (N=4: 2 cycles; N=5: 3 cycles).
REQ-017 SHALL carry a valid bit alongside each stage; out_valid is the last stage's valid bit.
REQ-018 SHALL advance all stages together when adv = !out_valid || out_ready; SHALL hold all stages, data and valid, when adv=0.
REQ-019 SHALL drive in_ready = adv combinationally; in_ready SHALL NOT depend on in_valid.
REQ-020 SHALL sustain one accepted vector per cycle while out_ready stays high.
REQ-021 SHALL hold outp and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL load a bubble (valid 0) into stage 1 when adv=1 and in_valid=0.
REQ-023 SHALL, when the output is consumed and a new vector accepted in the same cycle, lose no result and duplicate none.
REQ-024 SHALL reduce the full-precision sum to DW bits at the output per REQ-028/REQ-029.
REQ-025 SHALL keep outp at its last value when out_valid=0.

Reset
REQ-026 SHALL, while rst=1, clear every stage valid bit and every data register to 0 immediately, regardless of clk: out_valid=0, outp=0, in_ready=1.
REQ-027 SHALL discard all in-flight vectors on reset mid-operation; first result after release only from vectors accepted after release.

Configuration
REQ-028 SHALL, with macro ADD_N_PIPE_SAT_EN defined, saturate the final sum to the DW-bit range: unsigned 0..2^DW-1; signed -2^(DW-1)..2^(DW-1)-1.
REQ-029 SHALL, without ADD_N_PIPE_SAT_EN, output the low DW bits of the full sum (modulo 2^DW wrap).

Verification
REQ-030 SHALL cover: N=4, DW=8, SIGNED=0, inp elements 1,2,3,4, out_ready=1 -> outp=10, out_valid high exactly 2 cycles after acceptance.
REQ-031 SHALL cover: N=4, DW=8, SIGNED=0, elements 200,100,0,0 -> outp=44 without SAT_EN; outp=255 with ADD_N_PIPE_SAT_EN.
REQ-032 SHALL cover: N=4, DW=8, SIGNED=1, elements -128,-128,0,0 -> outp=0 without SAT_EN; outp=-128 (0x80) with it; elements -3,5,-1,1 -> outp=2.
REQ-033 SHALL cover: N=5, DW=8, 8 back-to-back vectors, out_ready low cycles 3..7 -> in_ready low while full and output held; all 8 sums delivered in order, none lost or repeated.
REQ-034 SHALL cover: rst asserted asynchronously mid-cycle with 2 vectors in flight -> out_valid=0 and outp=0 at once; neither sum ever appears after release.
REQ-035 SHALL cover: N=3, elements 7,8,9 with in_valid pulsed every other cycle -> outp=24 each time, out_valid alternating 1/0.
